// File: rtl/tdp_bist_pkg.sv
// Shared definitions for the true dual-port RAM BIST: FSM state encoding,
// pass-select constants and the address-derived pattern function.
package tdp_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // Pass 0 uses the seed as-is, pass 1 uses its complement.
  localparam logic PASS_FWD = 1'b0;
  localparam logic PASS_INV = 1'b1;

  // Working width of pat(); callers cast the result to their data width.
  localparam int unsigned PAT_MAX_W = 32;

  // Zero-extended address XOR (seed or ~seed).
  function automatic logic [PAT_MAX_W-1:0] pat(input logic [PAT_MAX_W-1:0] a,
                                               input logic [PAT_MAX_W-1:0] seed,
                                               input logic p);
    return a ^ (p ? ~seed : seed);
  endfunction

endpackage

// File: rtl/tdp_bist_cmp_pipe.sv
// Read-compare pipeline: delays {valid, address, pass} by RD_LAT cycles per
// port so they line up with the RAM read data, then flags mismatches.
module tdp_bist_cmp_pipe
  import tdp_bist_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 7,
  parameter logic [DATA_W-1:0] SEED   = 8'hAA,
  parameter int unsigned       RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              v1_i,
  input  logic              v2_i,
  input  logic [ADDR_W-1:0] a1_i,
  input  logic [ADDR_W-1:0] a2_i,
  input  logic              p_i,
  input  logic [DATA_W-1:0] q1_i,
  input  logic [DATA_W-1:0] q2_i,
  output logic              mism1_o,
  output logic              mism2_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o
);

  localparam int unsigned LAST = RD_LAT - 1;

  logic              v1_q [RD_LAT];
  logic              v2_q [RD_LAT];
  logic              p1_q [RD_LAT];
  logic              p2_q [RD_LAT];
  logic [ADDR_W-1:0] a1_q [RD_LAT];
  logic [ADDR_W-1:0] a2_q [RD_LAT];

  function automatic logic [DATA_W-1:0] pat_w(input logic [ADDR_W-1:0] a, input logic p);
    return DATA_W'(pat(PAT_MAX_W'(a), PAT_MAX_W'(SEED), p));
  endfunction

  // Shift the issued read descriptors along the read-latency delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        v1_q[k] <= 1'b0;
        v2_q[k] <= 1'b0;
        p1_q[k] <= 1'b0;
        p2_q[k] <= 1'b0;
        a1_q[k] <= {ADDR_W{1'b0}};
        a2_q[k] <= {ADDR_W{1'b0}};
      end
    end else if (clr_i) begin
      for (int k = 0; k < RD_LAT; k++) begin
        v1_q[k] <= 1'b0;
        v2_q[k] <= 1'b0;
        p1_q[k] <= 1'b0;
        p2_q[k] <= 1'b0;
        a1_q[k] <= {ADDR_W{1'b0}};
        a2_q[k] <= {ADDR_W{1'b0}};
      end
    end else begin
      v1_q[0] <= v1_i;
      v2_q[0] <= v2_i;
      p1_q[0] <= p_i;
      p2_q[0] <= p_i;
      a1_q[0] <= a1_i;
      a2_q[0] <= a2_i;
      for (int k = 1; k < RD_LAT; k++) begin
        v1_q[k] <= v1_q[k-1];
        v2_q[k] <= v2_q[k-1];
        p1_q[k] <= p1_q[k-1];
        p2_q[k] <= p2_q[k-1];
        a1_q[k] <= a1_q[k-1];
        a2_q[k] <= a2_q[k-1];
      end
    end
  end

  assign addr1_o = a1_q[LAST];
  assign addr2_o = a2_q[LAST];
  assign mism1_o = v1_q[LAST] & (q1_i != pat_w(a1_q[LAST], p1_q[LAST]));
  assign mism2_o = v2_q[LAST] & (q2_i != pat_w(a2_q[LAST], p2_q[LAST]));

endmodule

// File: rtl/tdp_ram_bist.sv
// BIST controller for an 8x128 true dual-port RAM. Writes each half through
// one port and reads it back through the other, two passes (seed, ~seed).
// Optional feature macro: TDP_BIST_ERR_COUNT_EN (count errors, never abort).
module tdp_ram_bist
  import tdp_bist_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 7,
  parameter logic [DATA_W-1:0] SEED   = 8'hAA,
  parameter int unsigned       RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic              we1,
  output logic              we2,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2
`ifdef TDP_BIST_ERR_COUNT_EN
  ,
  output logic [ADDR_W+1:0] err_count
`endif
);

  localparam int unsigned       CW           = ADDR_W - 1;
  localparam logic [CW-1:0]     CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_LAST     = {CW{1'b1}};
  localparam int unsigned       DRAIN_LAST_I = RD_LAT - 1;
  localparam logic [CW-1:0]     DRAIN_LAST   = DRAIN_LAST_I[CW-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ZERO    = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO    = {DATA_W{1'b0}};

  bist_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              p_q, p_d;
  logic              rd_v_q, rd_v_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_port_q, fail_port_d;
  logic              found_q, found_d;
  logic              start_acc_s;
  logic              mism1_s, mism2_s, chk_en_s, mism_any_s;
  logic [ADDR_W-1:0] cmp_a1_s, cmp_a2_s;

`ifdef TDP_BIST_ERR_COUNT_EN
  localparam int unsigned EW = ADDR_W + 2;
  logic [EW-1:0] err_q, err_d;

  function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] acc, input logic [1:0] inc);
    logic [EW:0] sum;
    sum = {1'b0, acc} + {{(EW-1){1'b0}}, inc};
    if (sum[EW]) begin
      return {EW{1'b1}};
    end else begin
      return sum[EW-1:0];
    end
  endfunction
`endif

  function automatic logic [DATA_W-1:0] pat_w(input logic [ADDR_W-1:0] a, input logic p);
    return DATA_W'(pat(PAT_MAX_W'(a), PAT_MAX_W'(SEED), p));
  endfunction

  tdp_bist_cmp_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED), .RD_LAT(RD_LAT)
  ) u_cmp (
    .clk(clk), .rst_n(rst_n), .clr_i(start_acc_s),
    .v1_i(rd_v_q), .v2_i(rd_v_q), .a1_i(a1_q), .a2_i(a2_q), .p_i(p_q),
    .q1_i(q1), .q2_i(q2),
    .mism1_o(mism1_s), .mism2_o(mism2_s), .addr1_o(cmp_a1_s), .addr2_o(cmp_a2_s)
  );

  // Read data is only meaningful while a read phase or its drain is active.
  assign chk_en_s   = (state_q == READ) || (state_q == DRAIN);
  assign mism_any_s = chk_en_s & (mism1_s | mism2_s);

  // Next-state, counter, fail capture and next RAM-side output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_port_d = fail_port_q;
    found_d     = found_q;
    start_acc_s = 1'b0;
    a1_d        = ADDR_ZERO;
    a2_d        = ADDR_ZERO;
    d1_d        = DATA_ZERO;
    d2_d        = DATA_ZERO;
    we1_d       = 1'b0;
    we2_d       = 1'b0;
    rd_v_d      = 1'b0;

    // First mismatch wins; port 1 has priority on a same-cycle tie.
    if (mism_any_s && !found_q) begin
      found_d     = 1'b1;
      fail_addr_d = mism1_s ? cmp_a1_s : cmp_a2_s;
      fail_port_d = mism1_s ? 1'b0 : 1'b1;
    end else begin
      found_d     = found_q;
    end

`ifdef TDP_BIST_ERR_COUNT_EN
    err_d = sat_add(err_q, {1'b0, chk_en_s & mism1_s} + {1'b0, chk_en_s & mism2_s});
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc_s = 1'b1;
          state_d     = WRITE;
          cnt_d       = CNT_ZERO;
          p_d         = PASS_FWD;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = ADDR_ZERO;
          fail_port_d = 1'b0;
          found_d     = 1'b0;
`ifdef TDP_BIST_ERR_COUNT_EN
          err_d       = {EW{1'b0}};
`endif
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = READ;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = CNT_ZERO;
          if (p_q == PASS_FWD) begin
            state_d = WRITE;
            p_d     = PASS_INV;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef TDP_BIST_ERR_COUNT_EN
            pass_d  = (err_d == {EW{1'b0}});
`else
            pass_d  = ~(found_q | mism_any_s);
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifndef TDP_BIST_ERR_COUNT_EN
    // Abort on the first mismatch; the RAM-side outputs go idle below.
    if (mism_any_s) begin
      state_d = DONE;
      cnt_d   = CNT_ZERO;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
`endif

    // RAM-side outputs follow the state and index being entered.
    if (state_d == WRITE) begin
      a1_d  = {1'b0, cnt_d};
      a2_d  = {1'b1, cnt_d};
      d1_d  = pat_w({1'b0, cnt_d}, p_d);
      d2_d  = pat_w({1'b1, cnt_d}, p_d);
      we1_d = 1'b1;
      we2_d = 1'b1;
    end else if (state_d == READ) begin
      a1_d   = {1'b1, cnt_d};
      a2_d   = {1'b0, cnt_d};
      rd_v_d = 1'b1;
    end else begin
      rd_v_d = 1'b0;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      p_q         <= PASS_FWD;
      rd_v_q      <= 1'b0;
      a1_q        <= ADDR_ZERO;
      a2_q        <= ADDR_ZERO;
      d1_q        <= DATA_ZERO;
      d2_q        <= DATA_ZERO;
      we1_q       <= 1'b0;
      we2_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_port_q <= 1'b0;
      found_q     <= 1'b0;
`ifdef TDP_BIST_ERR_COUNT_EN
      err_q       <= {EW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      rd_v_q      <= rd_v_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      we1_q       <= we1_d;
      we2_q       <= we2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_port_q <= fail_port_d;
      found_q     <= found_d;
`ifdef TDP_BIST_ERR_COUNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_port = fail_port_q;
  assign a1        = a1_q;
  assign a2        = a2_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign we1       = we1_q;
  assign we2       = we2_q;
`ifdef TDP_BIST_ERR_COUNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_tdp_ram_bist.sv
// Scoreboard bench for tdp_ram_bist with a behavioural dual-port RAM that can
// model stuck-at-0 faults on bit 0 at up to two addresses.
module tb_tdp_ram_bist;

  logic       clk, rst_n, start;
  logic       busy, done, pass, fail_port, we1, we2;
  logic [6:0] fail_addr, a1, a2;
  logic [7:0] d1, d2, q1, q2;
`ifdef TDP_BIST_ERR_COUNT_EN
  logic [8:0] err_count;
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  tdp_ram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_port(fail_port), .a1(a1), .a2(a2), .d1(d1), .d2(d2),
    .we1(we1), .we2(we2), .q1(q1), .q2(q2)
`ifdef TDP_BIST_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, read latency 1, with optional stuck-at-0 on bit 0.
  logic [7:0] mem [128];
  logic       fa_en, fb_en;
  logic [6:0] fa_addr, fb_addr;

  function automatic logic [7:0] rd(input logic [6:0] a);
    logic [7:0] v;
    v = mem[a];
    if ((fa_en && a == fa_addr) || (fb_en && a == fb_addr)) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (we1) mem[a1] <= d1;
    if (we2) mem[a2] <= d2;
    q1 <= rd(a1);
    q2 <= rd(a2);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       pass;
    logic [6:0] addr;
    logic       port;
    int         cycles;
    int         errs;
  } exp_t;

  exp_t exp_q [$];

  task automatic push_exp(input logic p, input logic [6:0] a, input logic pt, input int cyc, input int errs);
    exp_t e;
    e.pass = p; e.addr = a; e.port = pt; e.cycles = cyc; e.errs = errs;
    exp_q.push_back(e);
  endtask

  // Monitor: count busy cycles, check each completed run against the queue.
  int   busy_cnt = 0;
  logic done_prev = 1'b0;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
        end else begin
          m_e = exp_q.pop_front();
          chk("pass", pass, m_e.pass);
          chk("fail_addr", fail_addr, m_e.addr);
          chk("fail_port", fail_port, m_e.port);
          chk("busy_cycles", busy_cnt, m_e.cycles);
          chk("busy_at_done", busy, 1'b0);
          chk("we1_at_done", we1, 1'b0);
          chk("we2_at_done", we2, 1'b0);
`ifdef TDP_BIST_ERR_COUNT_EN
          chk("err_count", err_count, m_e.errs);
`endif
        end
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=%0b expected 1 within %0d cycles", done, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    fa_en = 1'b0; fb_en = 1'b0; fa_addr = 7'h00; fb_addr = 7'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail_addr", fail_addr, 7'h00);
    chk("rst_fail_port", fail_port, 1'b0);
    chk("rst_a1a2", {a1, a2}, 14'h0000);
    chk("rst_d1d2", {d1, d2}, 16'h0000);
    chk("rst_we", {we1, we2}, 2'b00);
`ifdef TDP_BIST_ERR_COUNT_EN
    chk("rst_err_count", err_count, 9'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_we", {we1, we2}, 2'b00);

    // Fault-free run; first writes appear the cycle after start.
    push_exp(1'b1, 7'h00, 1'b0, 258, 0);
    pulse_start();
    chk("wr0_busy", busy, 1'b1);
    chk("wr0_a1_d1", {a1, d1}, {7'h00, 8'hAA});
    chk("wr0_a2_d2", {a2, d2}, {7'h40, 8'hEA});
    chk("wr0_we", {we1, we2}, 2'b11);
    @(negedge clk);
    chk("wr1_a1_d1", {a1, d1}, {7'h01, 8'hAB});
    chk("wr1_a2_d2", {a2, d2}, {7'h41, 8'hEB});
    wait_done(400);

    // Lower-half fault, read by port 2; start from DONE clears done.
    fa_en = 1'b1; fa_addr = 7'h05;
    push_exp(1'b0, 7'h05, 1'b1, ERRC ? 258 : 71, 1);
    pulse_start();
    chk("rerun_done_clr", done, 1'b0);
    chk("rerun_busy", busy, 1'b1);
    wait_done(400);

    // Upper-half fault, read by port 1; previous fail info must clear.
    fa_addr = 7'h45;
    push_exp(1'b0, 7'h45, 1'b0, ERRC ? 258 : 71, 1);
    pulse_start();
    chk("clr_fail_port", fail_port, 1'b0);
    chk("clr_fail_addr", fail_addr, 7'h00);
    chk("clr_pass", pass, 1'b0);
    wait_done(400);

    // Both faults mismatch in the same read cycle: port 1 reported.
    fa_addr = 7'h05; fb_en = 1'b1; fb_addr = 7'h45;
    push_exp(1'b0, 7'h45, 1'b0, ERRC ? 258 : 71, 2);
    pulse_start();
    wait_done(400);

    // Clean run with start re-pulsed during write and read phases.
    fa_en = 1'b0; fb_en = 1'b0;
    push_exp(1'b1, 7'h00, 1'b0, 258, 0);
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (60) @(negedge clk);
    pulse_start();
    wait_done(400);

    // Asynchronous reset during write cycle 30.
    pulse_start();
    repeat (29) @(negedge clk);
    chk("wr30_a1", a1, 7'd29);
    chk("wr30_we", {we1, we2}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {we1, we2}, 2'b00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_a1a2", {a1, a2}, 14'h0000);
    chk("arst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_done", done, 1'b0);
    push_exp(1'b1, 7'h00, 1'b0, 258, 0);
    pulse_start();
    wait_done(400);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
